ram_input_reader: RTL and testbench

RAM_INPUT_READER -- requirements
Module: ram_input_reader

---
 rtl/ram_input_reader_if.sv | 45 ++++
 rtl/ram_input_reader.sv | 168 ++++++++++++++++
 tb/tb_ram_input_reader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_input_reader_if.sv
// ram_input_reader_if
//   Bundles the burst-request, RAM-read and output-stream signals of
//   ram_input_reader.
//   Signals:
//     start, base_addr, length    burst request (environment -> reader)
//     ram_addr / ram_q            RAM read address (reader -> RAM) and data (RAM -> reader)
//     out_data, out_valid         output stream (reader -> sink)
//     out_ready                   sink acceptance (sink -> reader)
//     busy, done                  status (reader -> environment)
//     checksum                    burst checksum, present only with RAM_INPUT_READER_CHECKSUM_EN
//   Modports: master = the reader, slave = the surrounding environment.
interface ram_input_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   length;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
`ifdef RAM_INPUT_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
`endif

  modport master (
    input  start, base_addr, length, ram_q, out_ready,
    output ram_addr, out_data, out_valid, busy, done
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    , output checksum
`endif
  );

  modport slave (
    output start, base_addr, length, ram_q, out_ready,
    input  ram_addr, out_data, out_valid, busy, done
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/ram_input_reader.sv
// ram_input_reader
//   Reads a burst of `length` words from a synchronous-read RAM, starting at
//   base_addr (addresses wrap modulo 2**ADDR_WIDTH), and streams them out
//   through a valid/ready interface via a 2-entry FIFO.
//   Ports:
//     clk    clock, all state changes on the rising edge
//     rst_n  synchronous active-low reset
//     bus    ram_input_reader_if.master (start/base_addr/length, ram_addr/ram_q,
//            out_data/out_valid/out_ready, busy, done[, checksum])
//   Optional feature: define RAM_INPUT_READER_CHECKSUM_EN to add the checksum
//   output (wrapping sum of the words transferred in the current burst).
//   Timing: a read is presented on ram_addr in cycle c, its data appears on
//   ram_q in c+1 and is written into the FIFO at the end of c+1.
module ram_input_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_input_reader_if.master bus
);

  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         issued_cnt;
  logic [CW-1:0]         xfer_cnt;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic                  rd_vld_p1;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  done_q;

  logic                  accept;
  logic                  accept_zero;
  logic                  issue;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign pop     = (fifo_cnt != 2'd0) && bus.out_ready;
  assign rd_addr = base_q + issued_cnt[ADDR_WIDTH-1:0];

  // Next state and per-cycle decisions.
  // Slots are counted after this cycle's transfer: a word leaving the FIFO
  // now frees its slot for the read issued now, which lets a 2-entry FIFO
  // sustain one word per cycle while never holding more than two.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    accept_zero = 1'b0;
    issue       = 1'b0;
    occupancy   = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1} - {2'b00, pop};
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            accept_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if ((issued_cnt < len_q) && (occupancy < 3'd2)) begin
          issue = 1'b1;
          if (issued_cnt + CW'(1) == len_q) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && (xfer_cnt + CW'(1) == len_q)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Burst parameters are only consulted outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= bus.base_addr;
      len_q  <= bus.length;
    end
  end

  // ---- stage p0: read issue (address on ram_addr this cycle) ----
  // ---- stage p1: RAM data on ram_q, written into the FIFO ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      xfer_cnt    <= '0;
      ram_addr_q  <= '0;
      rd_vld_p1   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= accept_zero || ((state == DRAIN) && (state_nxt == IDLE));
      rd_vld_p1 <= issue;
      if (accept) begin
        issued_cnt <= '0;
        xfer_cnt   <= '0;
      end
      if (issue) begin
        issued_cnt <= issued_cnt + CW'(1);
        ram_addr_q <= rd_addr;
      end
      if (pop) begin
        xfer_cnt <= xfer_cnt + CW'(1);
        rd_ptr   <= ~rd_ptr;
      end
      if (rd_vld_p1) begin
        fifo_mem[wr_ptr] <= bus.ram_q;
        wr_ptr           <= ~wr_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

  // ram_addr follows the read being issued and otherwise holds the last one.
  assign bus.ram_addr  = issue ? rd_addr : ram_addr_q;
  assign bus.out_data  = fifo_mem[rd_ptr];
  assign bus.out_valid = (fifo_cnt != 2'd0);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;

`ifdef RAM_INPUT_READER_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] wrap_add(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  logic [DATA_WIDTH-1:0] checksum_q;

  // Cleared by any accepted start, so a zero-length burst reports 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else if (accept || accept_zero) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= wrap_add(checksum_q, bus.out_data);
    end
  end

  assign bus.checksum = checksum_q;
`else
  // Checksum feature not built: no checksum state or port.
`endif

endmodule

// File: tb/tb_ram_input_reader.sv
// tb_ram_input_reader
//   Drives ram_input_reader through directed and randomized bursts with a
//   behavioural RAM and compares the streamed words, done pulse, stall
//   behaviour and (when built) checksum against a reference model that
//   simply lists RAM contents in address order.
module tb_ram_input_reader;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_input_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_input_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural synchronous-read RAM.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  int checks   = 0;
  int failures = 0;

  // Observations gathered by run_burst.
  logic [DW-1:0] got_q[$];
  int            xfer_cyc_q[$];
  int            done_cnt, done_cyc, done_busy_bad, stall_bad, first_valid;
  int            timed_out, busy_seen;
  logic [DW-1:0] cks_at_done;
  logic [AW-1:0] addr_after;

  // Reference model: expected words are RAM contents at base, base+1, ... wrapping.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_sum;

  function automatic void fill_exp(input int base, input int len);
    exp_q.delete();
    exp_sum = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[AW'((base + i) % DEPTH)]);
      exp_sum = DW'((int'(exp_sum) + int'(mem[AW'((base + i) % DEPTH)])) % 256);
    end
  endfunction

  function automatic void fill_random();
    for (int a = 0; a < DEPTH; a++) mem[AW'(a)] = DW'($urandom);
  endfunction

  // Starts a burst and watches it until a few cycles past done (or a cycle budget).
  // mode 0: out_ready=1; mode 1: out_ready 1,0,0,1 repeating; mode 2: random.
  task automatic run_burst(input logic [AW-1:0] base, input int len, input int mode,
                           input bit restart);
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            cyc;
    int            tail;
    got_q.delete();
    xfer_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; done_busy_bad = 0; stall_bad = 0;
    first_valid = -1; timed_out = 0; busy_seen = 0; cks_at_done = '0;
    prev_stall = 1'b0; prev_data = '0; tail = -1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len[AW:0];
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    forever begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart && cyc == 2) begin
        bus.start     = 1'b1;
        bus.base_addr = base + 6'd7;
        bus.length    = 7'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy === 1'b1) busy_seen++;
      if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== prev_data)) stall_bad++;
      if (bus.out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        xfer_cyc_q.push_back(cyc);
      end
      prev_stall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prev_data  = bus.out_data;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (bus.busy !== 1'b0) done_busy_bad++;
`ifdef RAM_INPUT_READER_CHECKSUM_EN
        cks_at_done = bus.checksum;
`endif
        if (tail < 0) tail = 3;
      end
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    addr_after    = bus.ram_addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ram_addr !== '0) begin failures++; $display("FAIL reset_ram_addr got=%0d exp=0", bus.ram_addr); end
    checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    checks++; if (bus.checksum !== '0) begin failures++; $display("FAIL reset_checksum got=%0d exp=0", bus.checksum); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int a = 0; a < DEPTH; a++) mem[AW'(a)] = DW'(a + 1);
    run_burst(6'd0, 4, 0, 1'b0);
    checks++; if (timed_out != 0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== DW'(i + 1)) begin failures++; $display("FAIL basic_word%0d got=%0d exp=%0d", i, got_q[i], i + 1); end
    end
    // out_valid rises on the second clock edge after the accepting edge.
    checks++; if (first_valid != 3) begin failures++; $display("FAIL basic_first_valid got=%0d exp=3", first_valid); end
    if (xfer_cyc_q.size() == 4) begin
      checks++;
      if (xfer_cyc_q[3] - xfer_cyc_q[0] != 3) begin failures++; $display("FAIL basic_throughput got=%0d exp=3", xfer_cyc_q[3] - xfer_cyc_q[0]); end
      checks++;
      if (done_cyc != xfer_cyc_q[3] + 1) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc, xfer_cyc_q[3] + 1); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_busy_bad != 0) begin failures++; $display("FAIL basic_busy_at_done got=%0d exp=0", done_busy_bad); end
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    checks++; if (cks_at_done !== 8'd10) begin failures++; $display("FAIL basic_checksum got=%0d exp=10", cks_at_done); end
`endif
  endtask

  task automatic test_wrap();
    fill_random();
    fill_exp(62, 4);
    run_burst(6'd62, 4, 0, 1'b0);
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL wrap_word%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (addr_after !== 6'd1) begin failures++; $display("FAIL wrap_last_addr got=%0d exp=1", addr_after); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL wrap_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] base;
    fill_random();
    base = AW'($urandom);
    fill_exp(int'(base), 8);
    run_burst(base, 8, 1, 1'b0);
    checks++; if (got_q.size() != 8) begin failures++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_word%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_bad); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    if (xfer_cyc_q.size() == 8) begin
      checks++;
      if (done_cyc != xfer_cyc_q[7] + 1) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=%0d", done_cyc, xfer_cyc_q[7] + 1); end
    end
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    checks++; if (cks_at_done !== exp_sum) begin failures++; $display("FAIL bp_checksum got=%0d exp=%0d", cks_at_done, exp_sum); end
`endif
  endtask

  task automatic test_zero_length();
    run_burst(AW'($urandom), 0, 0, 1'b0);
    checks++; if (done_cyc != 1) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=1", done_cyc); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    checks++; if (first_valid != -1) begin failures++; $display("FAIL zero_out_valid got=%0d exp=-1", first_valid); end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL zero_busy got=%0d exp=0", busy_seen); end
`ifdef RAM_INPUT_READER_CHECKSUM_EN
    checks++; if (cks_at_done !== '0) begin failures++; $display("FAIL zero_checksum got=%0d exp=0", cks_at_done); end
`endif
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int guard = 0;
    int done_seen = 0;
    fill_random();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = AW'($urandom);
    bus.length    = 7'd6;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (n < 2 && guard < 50) begin
      if (bus.out_valid === 1'b1) n++;
      guard++;
      @(negedge clk);
    end
    checks++; if (n != 2) begin failures++; $display("FAIL midrst_transfers got=%0d exp=2", n); end
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midrst_no_done got=%0d exp=0", done_seen); end
    fill_exp(0, 2);
    run_burst(6'd0, 2, 0, 1'b0);
    checks++; if (got_q.size() != 2) begin failures++; $display("FAIL midrst_new_count got=%0d exp=2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_new_word%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL midrst_new_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_restart_ignored();
    logic [AW-1:0] base;
    fill_random();
    base = AW'($urandom);
    fill_exp(int'(base), 5);
    run_burst(base, 5, 0, 1'b1);
    checks++; if (got_q.size() != 5) begin failures++; $display("FAIL restart_count got=%0d exp=5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_word%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_random();
    logic [AW-1:0] base;
    int            len;
    for (int t = 0; t < 6; t++) begin
      fill_random();
      base = AW'($urandom);
      len  = int'($urandom_range(1, 20));
      fill_exp(int'(base), len);
      run_burst(base, len, 2, 1'b0);
      checks++; if (timed_out != 0) begin failures++; $display("FAIL rand%0d_timeout got=%0d exp=0", t, timed_out); end
      checks++; if (got_q.size() != len) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", t, got_q.size(), len); end
      for (int i = 0; i < got_q.size() && i < len; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_word%0d got=%0d exp=%0d", t, i, got_q[i], exp_q[i]); end
      end
      checks++; if (stall_bad != 0) begin failures++; $display("FAIL rand%0d_stall_stable got=%0d exp=0", t, stall_bad); end
      checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done_count got=%0d exp=1", t, done_cnt); end
`ifdef RAM_INPUT_READER_CHECKSUM_EN
      checks++; if (cks_at_done !== exp_sum) begin failures++; $display("FAIL rand%0d_checksum got=%0d exp=%0d", t, cks_at_done, exp_sum); end
`endif
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.length    = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem[AW'(a)] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_mid_reset();
    test_restart_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
